hazard_check: RTL and testbench

- Pipeline stage between decode and schedule.
- Registers decoded instruction fields and presents them as CHECK_* to the schedule stage.
- Keeps a register scoreboard of in-flight destination registers. Holds decode (CHECK_STALL) and inserts a bubble on RAW/WAW hazards.
- On FLUSH, un-tracks the destinations of instructions killed in this stage and in schedule.

---
 rtl/hazard_check_pkg.sv | 33 +++
 rtl/hazard_check_scoreboard.sv | 51 +++++
 rtl/hazard_check.sv | 120 ++++++++++++
 tb/tb_hazard_check.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_check_pkg.sv
// Shared types and constants for the decode->schedule hazard stage.
package hazard_check_pkg;

    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;

    localparam logic [6:0] BUBBLE_OPCODE = 7'd0;

    // Destination of an instruction still killable by a flush.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
    } slot_t;

    localparam slot_t SLOT_NONE = '{valid: 1'b0, rd: '0};

    // Registered instruction fields handed to schedule.
    typedef struct packed {
        logic [31:0]      pc;
        logic [6:0]       opcode;
        logic [REG_W-1:0] rd;
        logic [11:0]      csr;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [31:0]      imm;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '{
        pc: '0, opcode: BUBBLE_OPCODE, rd: '0, csr: '0,
        funct3: '0, funct7: '0, imm: '0
    };

endpackage

// File: rtl/hazard_check_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 never set.
module hazard_check_scoreboard
    import hazard_check_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_idx,
    input  logic             wb_en,
    input  logic [REG_W-1:0] wb_idx,
    input  logic             fl0_en,
    input  logic [REG_W-1:0] fl0_idx,
    input  logic             fl1_en,
    input  logic [REG_W-1:0] fl1_idx,
    input  logic [REG_W-1:0] rs1_idx,
    input  logic [REG_W-1:0] rs2_idx,
    input  logic [REG_W-1:0] rd_idx,
    output logic             rs1_pend,
    output logic             rs2_pend,
    output logic             rd_pend
);

    localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [NUM_REGS-1:0] set_oh, clr_oh;

    always_comb begin
        set_oh = set_en ? (ONE << set_idx) : '0;
        clr_oh = '0;
        if (wb_en)  clr_oh = clr_oh | (ONE << wb_idx);
        if (fl0_en) clr_oh = clr_oh | (ONE << fl0_idx);
        if (fl1_en) clr_oh = clr_oh | (ONE << fl1_idx);
    end

    // Set wins over clear for the same index.
    always_comb begin
        pend_d    = (pend_q & ~clr_oh) | set_oh;
        pend_d[0] = 1'b0;
        if (RST) pend_d = '0;
    end

    always_ff @(posedge CLK) begin
        pend_q <= pend_d;
    end

    assign rs1_pend = pend_q[rs1_idx];
    assign rs2_pend = pend_q[rs2_idx];
    assign rd_pend  = pend_q[rd_idx];

endmodule

// File: rtl/hazard_check.sv
// Decode->schedule stage: registers decoded fields and stalls decode on RAW/WAW hazards.
module hazard_check
    import hazard_check_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             STALL,
    input  logic             MEM_WAIT,
    input  logic             DECODE_VALID,
    input  logic [31:0]      DECODE_PC,
    input  logic [6:0]       DECODE_OPCODE,
    input  logic [REG_W-1:0] DECODE_RD,
    input  logic             DECODE_RD_WRITE,
    input  logic [REG_W-1:0] DECODE_RS1,
    input  logic             DECODE_RS1_USE,
    input  logic [REG_W-1:0] DECODE_RS2,
    input  logic             DECODE_RS2_USE,
    input  logic [11:0]      DECODE_CSR,
    input  logic [2:0]       DECODE_FUNCT3,
    input  logic [6:0]       DECODE_FUNCT7,
    input  logic [31:0]      DECODE_IMM,
    input  logic             WB_VALID,
    input  logic [REG_W-1:0] WB_RD,
    output logic             CHECK_STALL,
    output logic             CHECK_VALID,
    output logic [31:0]      CHECK_PC,
    output logic [6:0]       CHECK_OPCODE,
    output logic [REG_W-1:0] CHECK_RD,
    output logic [11:0]      CHECK_CSR,
    output logic [2:0]       CHECK_FUNCT3,
    output logic [6:0]       CHECK_FUNCT7,
    output logic [31:0]      CHECK_IMM
);

    logic   trk, hold, hz, issue;
    logic   rs1_pend, rs2_pend, rd_pend;
    stage_t dec;
    stage_t stage_q, stage_d;
    logic   valid_q, valid_d;
    slot_t  slot0_q, slot0_d, slot1_q, slot1_d;

    assign trk  = DECODE_RD_WRITE && (DECODE_RD != '0);
    assign hold = STALL || MEM_WAIT;

    // Checked against registered pend only; a writeback frees the stall a cycle later.
    assign hz = DECODE_VALID &&
                ((DECODE_RS1_USE && (DECODE_RS1 != '0) && rs1_pend) ||
                 (DECODE_RS2_USE && (DECODE_RS2 != '0) && rs2_pend) ||
                 (trk && rd_pend));

    assign issue = DECODE_VALID && !hz && !hold && !FLUSH && !RST;

    assign dec = '{
        pc: DECODE_PC, opcode: DECODE_OPCODE, rd: DECODE_RD, csr: DECODE_CSR,
        funct3: DECODE_FUNCT3, funct7: DECODE_FUNCT7, imm: DECODE_IMM
    };

    hazard_check_scoreboard u_sb (
        .CLK      (CLK),
        .RST      (RST),
        .set_en   (issue && trk),
        .set_idx  (DECODE_RD),
        .wb_en    (WB_VALID),
        .wb_idx   (WB_RD),
        .fl0_en   (FLUSH && slot0_q.valid),
        .fl0_idx  (slot0_q.rd),
        .fl1_en   (FLUSH && slot1_q.valid),
        .fl1_idx  (slot1_q.rd),
        .rs1_idx  (DECODE_RS1),
        .rs2_idx  (DECODE_RS2),
        .rd_idx   (DECODE_RD),
        .rs1_pend (rs1_pend),
        .rs2_pend (rs2_pend),
        .rd_pend  (rd_pend)
    );

    always_comb begin
        stage_d = stage_q;
        valid_d = valid_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (RST || FLUSH) begin
            stage_d = STAGE_BUBBLE;
            valid_d = 1'b0;
            slot0_d = SLOT_NONE;
            slot1_d = SLOT_NONE;
        end else if (!hold) begin
            // slot1 leaving here is committed to exec; its pend bit waits for writeback.
            slot1_d = slot0_q;
            if (issue) begin
                stage_d = dec;
                valid_d = 1'b1;
                slot0_d = '{valid: trk, rd: DECODE_RD};
            end else begin
                stage_d = STAGE_BUBBLE;
                valid_d = 1'b0;
                slot0_d = SLOT_NONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        stage_q <= stage_d;
        valid_q <= valid_d;
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
    end

    assign CHECK_STALL  = hz;
    assign CHECK_VALID  = valid_q;
    assign CHECK_PC     = stage_q.pc;
    assign CHECK_OPCODE = stage_q.opcode;
    assign CHECK_RD     = stage_q.rd;
    assign CHECK_CSR    = stage_q.csr;
    assign CHECK_FUNCT3 = stage_q.funct3;
    assign CHECK_FUNCT7 = stage_q.funct7;
    assign CHECK_IMM    = stage_q.imm;

endmodule

// File: tb/tb_hazard_check.sv
// Randomized scoreboard bench for hazard_check against a set-of-in-flight-writes model.
module tb_hazard_check;

    logic        CLK = 1'b0;
    logic        RST, FLUSH, STALL, MEM_WAIT;
    logic        DECODE_VALID, DECODE_RD_WRITE, DECODE_RS1_USE, DECODE_RS2_USE;
    logic [31:0] DECODE_PC, DECODE_IMM;
    logic [6:0]  DECODE_OPCODE, DECODE_FUNCT7;
    logic [4:0]  DECODE_RD, DECODE_RS1, DECODE_RS2, WB_RD;
    logic [11:0] DECODE_CSR;
    logic [2:0]  DECODE_FUNCT3;
    logic        WB_VALID;
    logic        CHECK_STALL, CHECK_VALID;
    logic [31:0] CHECK_PC, CHECK_IMM;
    logic [6:0]  CHECK_OPCODE, CHECK_FUNCT7;
    logic [4:0]  CHECK_RD;
    logic [11:0] CHECK_CSR;
    logic [2:0]  CHECK_FUNCT3;

    hazard_check dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .STALL(STALL), .MEM_WAIT(MEM_WAIT),
        .DECODE_VALID(DECODE_VALID), .DECODE_PC(DECODE_PC), .DECODE_OPCODE(DECODE_OPCODE),
        .DECODE_RD(DECODE_RD), .DECODE_RD_WRITE(DECODE_RD_WRITE),
        .DECODE_RS1(DECODE_RS1), .DECODE_RS1_USE(DECODE_RS1_USE),
        .DECODE_RS2(DECODE_RS2), .DECODE_RS2_USE(DECODE_RS2_USE),
        .DECODE_CSR(DECODE_CSR), .DECODE_FUNCT3(DECODE_FUNCT3), .DECODE_FUNCT7(DECODE_FUNCT7),
        .DECODE_IMM(DECODE_IMM), .WB_VALID(WB_VALID), .WB_RD(WB_RD),
        .CHECK_STALL(CHECK_STALL), .CHECK_VALID(CHECK_VALID), .CHECK_PC(CHECK_PC),
        .CHECK_OPCODE(CHECK_OPCODE), .CHECK_RD(CHECK_RD), .CHECK_CSR(CHECK_CSR),
        .CHECK_FUNCT3(CHECK_FUNCT3), .CHECK_FUNCT7(CHECK_FUNCT7), .CHECK_IMM(CHECK_IMM)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit        v;
        bit [31:0] pc;
        bit [6:0]  op;
        bit [4:0]  rd;
        bit        rdw;
        bit [4:0]  rs1;
        bit        u1;
        bit [4:0]  rs2;
        bit        u2;
        bit [11:0] csr;
        bit [2:0]  f3;
        bit [6:0]  f7;
        bit [31:0] imm;
    } dec_t;

    typedef struct {
        bit        stall;
        bit        valid;
        bit [97:0] payload;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: which registers have an unretired write, and which
    // tracked destinations were issued in the last two advancing cycles.
    bit        inflight[32];
    int        young [2];
    bit        out_valid;
    bit [97:0] out_payload;

    function automatic bit [97:0] pack(dec_t d);
        return {d.pc, d.op, d.rd, d.csr, d.f3, d.f7, d.imm};
    endfunction

    function automatic bit model_hz(dec_t d);
        if (!d.v) return 1'b0;
        if (d.u1 && d.rs1 != 0 && inflight[d.rs1]) return 1'b1;
        if (d.u2 && d.rs2 != 0 && inflight[d.rs2]) return 1'b1;
        if (d.rdw && d.rd != 0 && inflight[d.rd]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit [4:0] rand_reg();
        if ($urandom_range(0, 9) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic dec_t rand_dec();
        dec_t d;
        d.v   = ($urandom_range(0, 9) < 8);
        d.pc  = $urandom;
        d.op  = 7'($urandom);
        d.rd  = rand_reg();
        d.rdw = ($urandom_range(0, 9) < 8);
        d.rs1 = rand_reg();
        d.u1  = ($urandom_range(0, 9) < 6);
        d.rs2 = rand_reg();
        d.u2  = ($urandom_range(0, 9) < 4);
        d.csr = 12'($urandom);
        d.f3  = 3'($urandom);
        d.f7  = 7'($urandom);
        d.imm = $urandom;
        return d;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) inflight[r] = 1'b0;
        young[0]    = -1;
        young[1]    = -1;
        out_valid   = 1'b0;
        out_payload = '0;
    endfunction

    // Monitor: every cycle the DUT presents a stall decision and registered outputs.
    initial begin
        exp_t e;
        bit [97:0] act;
        forever begin
            @(negedge CLK);
            if (expq.size() > 0) begin
                e   = expq.pop_front();
                act = {CHECK_PC, CHECK_OPCODE, CHECK_RD, CHECK_CSR,
                       CHECK_FUNCT3, CHECK_FUNCT7, CHECK_IMM};
                checks++;
                if (CHECK_STALL !== e.stall) begin
                    errors++;
                    $display("FAIL stall t=%0t got %b want %b", $time, CHECK_STALL, e.stall);
                end
                checks++;
                if (CHECK_VALID !== e.valid) begin
                    errors++;
                    $display("FAIL valid t=%0t got %b want %b", $time, CHECK_VALID, e.valid);
                end
                checks++;
                if (act !== e.payload) begin
                    errors++;
                    $display("FAIL payload t=%0t got %h want %h", $time, act, e.payload);
                end
            end
        end
    end

    initial begin
        dec_t cur;
        bit   keep, hz, hold, rst_b, fl_b, wb_v, trk;
        bit [4:0] wb_r;
        int   cand[$];
        exp_t e;

        RST = 1'b1; FLUSH = 1'b0; STALL = 1'b0; MEM_WAIT = 1'b0;
        DECODE_VALID = 1'b0; DECODE_PC = '0; DECODE_OPCODE = '0; DECODE_RD = '0;
        DECODE_RD_WRITE = 1'b0; DECODE_RS1 = '0; DECODE_RS1_USE = 1'b0;
        DECODE_RS2 = '0; DECODE_RS2_USE = 1'b0; DECODE_CSR = '0; DECODE_FUNCT3 = '0;
        DECODE_FUNCT7 = '0; DECODE_IMM = '0; WB_VALID = 1'b0; WB_RD = '0;
        model_reset();
        keep = 1'b0;
        cur  = rand_dec();
        repeat (2) @(posedge CLK);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge CLK);
            #1;
            rst_b = (cyc == 0) || ($urandom_range(0, 299) == 0);
            fl_b  = ($urandom_range(0, 31) == 0);
            STALL    = ($urandom_range(0, 19) == 0);
            MEM_WAIT = ($urandom_range(0, 19) == 0);
            hold     = STALL || MEM_WAIT;
            if (!keep) cur = rand_dec();

            // Retire only writes already committed past the flushable slots.
            cand.delete();
            for (int r = 1; r < 32; r++)
                if (inflight[r] && r != young[0] && r != young[1]) cand.push_back(r);
            wb_v = (cand.size() > 0) && ($urandom_range(0, 99) < 35);
            wb_r = wb_v ? 5'(cand[$urandom_range(0, cand.size() - 1)]) : 5'($urandom);

            RST = rst_b; FLUSH = fl_b; WB_VALID = wb_v; WB_RD = wb_r;
            DECODE_VALID = cur.v; DECODE_PC = cur.pc; DECODE_OPCODE = cur.op;
            DECODE_RD = cur.rd; DECODE_RD_WRITE = cur.rdw;
            DECODE_RS1 = cur.rs1; DECODE_RS1_USE = cur.u1;
            DECODE_RS2 = cur.rs2; DECODE_RS2_USE = cur.u2;
            DECODE_CSR = cur.csr; DECODE_FUNCT3 = cur.f3; DECODE_FUNCT7 = cur.f7;
            DECODE_IMM = cur.imm;

            hz  = model_hz(cur);
            trk = cur.rdw && cur.rd != 0;
            e.stall   = hz;
            e.valid   = out_valid;
            e.payload = out_payload;
            expq.push_back(e);

            assert (!(wb_v && wb_r != 0 && cur.v && !hz && !hold && !fl_b && !rst_b
                      && trk && wb_r == cur.rd))
                else $error("set and clear of x%0d in one cycle", wb_r);

            if (rst_b) begin
                model_reset();
            end else begin
                if (wb_v && wb_r != 0) inflight[wb_r] = 1'b0;
                if (fl_b) begin
                    if (young[0] >= 0) inflight[young[0]] = 1'b0;
                    if (young[1] >= 0) inflight[young[1]] = 1'b0;
                    young[0] = -1; young[1] = -1;
                    out_valid = 1'b0; out_payload = '0;
                end else if (!hold) begin
                    young[1] = young[0];
                    if (cur.v && !hz) begin
                        out_valid   = 1'b1;
                        out_payload = pack(cur);
                        young[0]    = trk ? int'(cur.rd) : -1;
                        if (trk) inflight[cur.rd] = 1'b1;
                    end else begin
                        out_valid = 1'b0; out_payload = '0;
                        young[0]  = -1;
                    end
                end
            end
            keep = cur.v && !rst_b && !fl_b && (hz || hold);
        end

        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge CLK);
        @(negedge CLK);
        if (expq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending want 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
